// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive sequencer owning the oversampling edge/bit counters,
// datapath enables and frame-end status pulses; all outputs are registered.
module uart_rx_fsm #(
  parameter int DATA_LENGTH = 8
) (
  input  logic       CLK_fsm,
  input  logic       RST_fsm,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       PAR_EN,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       par_error,
  output logic       framing_error
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  localparam logic [3:0] BIT_LAST = 4'(DATA_LENGTH - 1);
  state_t     state_q, state_d;
  logic [5:0] edge_q, edge_d, p_q, p_d;
  logic [3:0] bit_q, bit_d;
  logic       pe_q, pe_d, pf_q, pf_d, sf_q, sf_d;
  logic       last, run;
  assign last = edge_q == p_q - 6'd1;
  assign run = state_q inside {START, DATA, PARITY, STOP};
  assign edge_cnt = edge_q;
  assign bit_cnt = bit_q;
  always_comb begin
    state_d = state_q;
    edge_d = run ? (last ? 6'd0 : edge_q + 6'd1) : 6'd0;
    bit_d = bit_q;
    p_d = p_q;
    pe_d = pe_q;
    pf_d = pf_q;
    sf_d = sf_q;
    case (state_q)
      IDLE: begin
        bit_d = 4'd0;
        if (!RX_IN) begin
          state_d = START;
          p_d = (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;
          pe_d = PAR_EN;
        end
      end
      START: if (last) begin
        state_d = strt_glitch ? IDLE : DATA;
        bit_d = 4'd0;
      end
      DATA: if (last) begin
        bit_d = (bit_q == BIT_LAST) ? 4'd0 : bit_q + 4'd1;
        state_d = (bit_q != BIT_LAST) ? DATA : (pe_q ? PARITY : STOP);
      end
      PARITY: if (last) begin
        pf_d = par_err;
        state_d = STOP;
      end
      STOP: if (last) begin
        sf_d = stp_err;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        pf_d = 1'b0;
        sf_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Enables and pulses are registered from the next state so they align with state_q.
  always_ff @(posedge CLK_fsm or negedge RST_fsm) begin
    if (!RST_fsm) begin
      state_q <= IDLE;
      edge_q <= 6'd0;
      bit_q <= 4'd0;
      p_q <= 6'd8;
      pe_q <= 1'b0;
      pf_q <= 1'b0;
      sf_q <= 1'b0;
      dat_samp_en <= 1'b0;
      deser_en <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en <= 1'b0;
      stp_chk_en <= 1'b0;
      data_valid <= 1'b0;
      par_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q <= edge_d;
      bit_q <= bit_d;
      p_q <= p_d;
      pe_q <= pe_d;
      pf_q <= pf_d;
      sf_q <= sf_d;
      dat_samp_en <= state_d inside {START, DATA, PARITY, STOP};
      deser_en <= state_d == DATA;
      strt_chk_en <= state_d == START;
      par_chk_en <= state_d == PARITY;
      stp_chk_en <= state_d == STOP;
      data_valid <= state_d == DONE && !pf_d && !sf_d;
      par_error <= state_d == DONE && pf_d;
      framing_error <= state_d == DONE && sf_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames with a scoreboard queue; a negedge monitor
// pops and checks whenever a frame-end pulse appears.
module tb_uart_rx_fsm;
  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, pen = 1'b0;
  logic [5:0] ps = 6'd8;
  logic       want_g = 1'b0, want_p = 1'b0, want_s = 1'b0;
  logic       strt_glitch, par_err, stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, par_error, framing_error;
  uart_rx_fsm #(.DATA_LENGTH(8)) dut (
    .CLK_fsm(clk), .RST_fsm(rst_n), .RX_IN(rx), .prescale(ps), .PAR_EN(pen),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .par_error(par_error),
    .framing_error(framing_error)
  );
  always #5 clk = ~clk;
  // Checker results are only meaningful while the matching enable is high.
  assign strt_glitch = strt_chk_en & want_g;
  assign par_err = par_chk_en & want_p;
  assign stp_err = stp_chk_en & want_s;
  typedef struct {
    logic   dv, pe, fe;
    int     sh, pc;
    longint start;
    int     lat;
  } exp_t;
  exp_t   q[$];
  exp_t   e;
  longint cyc = 0;
  int     cur_per = 8, ncmp = 0, nerr = 0, sh = 0, pc = 0;
  bit     last = 1'b0, done = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
          par_chk_en, stp_chk_en, data_valid, par_error, framing_error}, 0);
      sh = 0;
      pc = 0;
      last = 1'b0;
    end else begin
      if (deser_en && edge_cnt == 6'(cur_per - 1)) sh++;
      if (par_chk_en) pc++;
      if (last) begin
        chk("pulse_width", {data_valid, par_error, framing_error}, 0);
        last = 1'b0;
      end else if (data_valid | par_error | framing_error) begin
        if (q.size() == 0) chk("unexpected_pulse", {data_valid, par_error, framing_error}, 0);
        else begin
          e = q.pop_front();
          chk("data_valid", data_valid, e.dv);
          chk("par_error", par_error, e.pe);
          chk("framing_error", framing_error, e.fe);
          chk("shift_edges", sh, e.sh);
          chk("parity_cycles", pc, e.pc);
          chk("latency", cyc - e.start, e.lat);
        end
        sh = 0;
        pc = 0;
        last = 1'b1;
      end
    end
    if (done) begin
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
    end
  end
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] d, input logic [5:0] p, input int per,
                       input logic pe_in, input logic bp, input logic bs,
                       input logic chg, input int lat, input int abort);
    logic [10:0] bits;
    exp_t x;
    int n, c;
    ps = p;
    pen = pe_in;
    want_p = bp;
    want_s = bs;
    cur_per = per;
    n = pe_in ? 11 : 10;
    c = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pe_in) bits[9] = ^d ^ bp;
    bits[n-1] = !bs;
    if (abort == 0) begin
      x.dv = !bp && !bs;
      x.pe = bp;
      x.fe = bs;
      x.sh = 8;
      x.pc = pe_in ? per : 0;
      x.start = cyc;
      x.lat = lat;
      q.push_back(x);
    end
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < per; k++) begin
        rx = bits[b];
        if (chg && b == 1 && k == 0) begin ps = 6'd8; pen = !pe_in; end
        if (chg && b == n - 1 && k == 0) begin ps = p; pen = pe_in; end
        @(negedge clk);
        c++;
        if (abort != 0 && c == abort) begin
          @(posedge clk);
          #1 rst_n = 1'b0;
          repeat (2) @(negedge clk);
          #1 rst_n = 1'b1;
          rx = 1'b1;
          return;
        end
      end
    end
    rx = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    frame(8'hA5, 6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 89, 0);
    idle(12);
    frame(8'hA5, 6'd8, 8, 1'b1, 1'b1, 1'b0, 1'b0, 89, 0);
    idle(12);
    frame(8'h3C, 6'd16, 16, 1'b0, 1'b0, 1'b1, 1'b0, 161, 0);
    idle(12);
    ps = 6'd8;
    want_g = 1'b1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    want_g = 1'b0;
    frame(8'h01, 6'd32, 32, 1'b0, 1'b0, 1'b0, 1'b1, 321, 0);
    frame(8'hFF, 6'd32, 32, 1'b0, 1'b0, 1'b0, 1'b0, 323, 0);
    idle(12);
    frame(8'h0F, 6'd12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 81, 0);
    idle(12);
    frame(8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 43);
    idle(8);
    frame(8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 81, 0);
    idle(12);
    done = 1'b1;
  end
endmodule
